// File: rtl/bcrypt_sched.sv
// -----------------------------------------------------------------------------
// bcrypt_sched
//
// Sequencing controller for the bcrypt EksBlowfish datapath. After an accepted
// start it walks the datapath through one INIT ExpandKey, 2^cost pairs of
// (key, salt) ExpandKey loops, and the 64x3 ciphertext block encryption. It
// issues one strobe per cycle for each datapath action.
//
// Each ExpandKey is one XOR cycle followed by 521 blocks. Every block is
// LOAD, 16 x ROUND, STORE. Blocks 0..8 store to the P pairs and blocks 9..520
// store to the S-box pairs. The ciphertext phase runs 192 blocks with no
// stores to P or S.
//
// Optional feature macro: BCRYPT_SCHED_COST_CHECK_EN
//   When defined, a start with cost < MIN_COST is refused. The block pulses
//   err and stays idle. When undefined, every cost 0..31 is accepted and err
//   is constant 0.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   one-cycle hash request, sampled only while idle
//   cost[4:0] in   log2 iteration count, latched on accepted start
//   hold      in   stall: freezes state/counters, gates all strobes low
//   p_xor     out  P ^= selected key/salt vector
//   key_sel   out  0 = key, 1 = salt
//   blk_load  out  load L,R for a new block
//   salt_mix  out  XOR next salt half into L,R on load
//   round_en  out  one Feistel round
//   round_idx out  round number 0..15 (0 when round_en is low)
//   store_p   out  write L,R to P pair selected by psel
//   psel[8:0] out  one-hot P pair select
//   store_s   out  write L,R to S pair at s_addr
//   s_addr    out  S pair index: [8:7] box, [6:0] pair
//   ct_load   out  current block is a ciphertext block
//   busy      out  hash in progress
//   done      out  one-cycle completion pulse
//   err       out  one-cycle illegal-cost pulse
// -----------------------------------------------------------------------------
module bcrypt_sched #(
   parameter int MIN_COST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] cost,
   input  logic       hold,
   output logic       p_xor,
   output logic       key_sel,
   output logic       blk_load,
   output logic       salt_mix,
   output logic       round_en,
   output logic [3:0] round_idx,
   output logic       store_p,
   output logic [8:0] psel,
   output logic       store_s,
   output logic [8:0] s_addr,
   output logic       ct_load,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_XOR, S_LOAD, S_ROUND, S_STORE, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_INIT, PH_LOOP_KEY, PH_LOOP_SALT, PH_CTEXT
   } phase_t;

`ifdef BCRYPT_SCHED_COST_CHECK_EN
   localparam logic LP_COST_CHECK = 1'b1;
`else
   localparam logic LP_COST_CHECK = 1'b0;
`endif

   localparam logic [9:0] LP_LAST_BLK = 10'd520;
   localparam logic [9:0] LP_P_BLKS   = 10'd9;
   localparam logic [7:0] LP_LAST_CT  = 8'd191;

   state_t      r_state, w_state_nxt;
   phase_t      r_phase, w_phase_nxt;
   logic [3:0]  r_round, w_round_nxt;
   logic [9:0]  r_blk,   w_blk_nxt;
   logic [31:0] r_iter,  w_iter_nxt;
   logic [7:0]  r_ct,    w_ct_nxt;
   logic [4:0]  r_cost,  w_cost_nxt;
   logic        r_err,   w_err_nxt;

   logic        w_cost_low;
   logic        w_accept;
   logic        w_adv;
   logic [31:0] w_iter_inc;
   logic [31:0] w_target;
   logic        w_expand;
   logic        w_p_blk;
   logic [9:0]  w_s_idx;

   // With the check disabled LP_COST_CHECK is 0, so no start is refused and
   // r_err never leaves 0.
   assign w_cost_low = ({27'd0, cost} < MIN_COST);
   assign w_accept   = start & ~(w_cost_low & LP_COST_CHECK);

   // hold freezes everything except the idle state, where it has no effect.
   assign w_adv      = ~hold | (r_state == S_IDLE);

   // The counter must reach 2^cost exactly; for cost 31 this is bit 31.
   assign w_iter_inc = r_iter + 32'd1;
   assign w_target   = 32'd1 << r_cost;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_phase <= PH_INIT;
         r_round <= 4'd0;
         r_blk   <= 10'd0;
         r_iter  <= 32'd0;
         r_ct    <= 8'd0;
         r_cost  <= 5'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_round <= w_round_nxt;
         r_blk   <= w_blk_nxt;
         r_iter  <= w_iter_nxt;
         r_ct    <= w_ct_nxt;
         r_cost  <= w_cost_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_round_nxt = r_round;
      w_blk_nxt   = r_blk;
      w_iter_nxt  = r_iter;
      w_ct_nxt    = r_ct;
      w_cost_nxt  = r_cost;
      w_err_nxt   = (r_state == S_IDLE) & start & w_cost_low & LP_COST_CHECK;

      if (w_adv) begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = S_XOR;
                  w_phase_nxt = PH_INIT;
                  w_round_nxt = 4'd0;
                  w_blk_nxt   = 10'd0;
                  w_iter_nxt  = 32'd0;
                  w_ct_nxt    = 8'd0;
                  w_cost_nxt  = cost;
               end
            end
            S_XOR: begin
               w_state_nxt = S_LOAD;
               w_blk_nxt   = 10'd0;
            end
            S_LOAD: begin
               w_state_nxt = S_ROUND;
               w_round_nxt = 4'd0;
            end
            S_ROUND: begin
               if (r_round == 4'd15) begin
                  w_state_nxt = S_STORE;
                  w_round_nxt = 4'd0;
               end else begin
                  w_round_nxt = r_round + 4'd1;
               end
            end
            S_STORE: begin
               if (r_phase == PH_CTEXT) begin
                  if (r_ct == LP_LAST_CT) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_ct_nxt    = r_ct + 8'd1;
                     w_state_nxt = S_LOAD;
                  end
               end else if (r_blk == LP_LAST_BLK) begin
                  // End of one ExpandKey: choose the next phase.
                  w_blk_nxt = 10'd0;
                  case (r_phase)
                     PH_INIT: begin
                        w_phase_nxt = PH_LOOP_KEY;
                        w_state_nxt = S_XOR;
                     end
                     PH_LOOP_KEY: begin
                        w_phase_nxt = PH_LOOP_SALT;
                        w_state_nxt = S_XOR;
                     end
                     default: begin
                        w_iter_nxt = w_iter_inc;
                        if (w_iter_inc == w_target) begin
                           w_phase_nxt = PH_CTEXT;
                           w_state_nxt = S_LOAD;
                           w_ct_nxt    = 8'd0;
                        end else begin
                           w_phase_nxt = PH_LOOP_KEY;
                           w_state_nxt = S_XOR;
                        end
                     end
                  endcase
               end else begin
                  w_blk_nxt   = r_blk + 10'd1;
                  w_state_nxt = S_LOAD;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
               w_phase_nxt = PH_INIT;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode only registered state, so inputs have no combinational
   // path to them. The one exception is hold, which gates the strobes.
   assign w_expand  = (r_phase != PH_CTEXT);
   assign w_p_blk   = (r_blk < LP_P_BLKS);
   assign w_s_idx   = r_blk - LP_P_BLKS;

   assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign p_xor     = (r_state == S_XOR) & ~hold;
   assign blk_load  = (r_state == S_LOAD) & ~hold;
   // INIT loads take salt words, so key_sel is forced to salt there.
   assign key_sel   = busy & ((r_phase == PH_LOOP_SALT) |
                              ((r_phase == PH_INIT) & (r_state == S_LOAD)));
   assign salt_mix  = blk_load & (r_phase == PH_INIT);
   assign round_en  = (r_state == S_ROUND) & ~hold;
   assign round_idx = round_en ? r_round : 4'd0;
   assign store_p   = (r_state == S_STORE) & w_expand & w_p_blk & ~hold;
   assign store_s   = (r_state == S_STORE) & w_expand & ~w_p_blk & ~hold;
   assign psel      = ((r_state == S_STORE) && w_expand && w_p_blk) ?
                      (9'd1 << r_blk[3:0]) : 9'd0;
   assign s_addr    = ((r_state == S_STORE) && w_expand && !w_p_blk) ?
                      w_s_idx[8:0] : 9'd0;
   assign ct_load   = (r_phase == PH_CTEXT) &&
                      ((r_state == S_LOAD) || (r_state == S_ROUND) ||
                       (r_state == S_STORE));
   assign done      = (r_state == S_DONE) & ~hold;
   assign err       = r_err;

endmodule
